// File: rtl/arb2_pkg.sv
// Shared types for the two-input round-robin stream arbiter.
package arb2_pkg;

    typedef enum logic {SRC0 = 1'b0, SRC1 = 1'b1} src_t;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_t;

    // Source 0 wins the first contention after reset.
    localparam src_t LAST_RST = SRC1;

endpackage

// File: rtl/mux21.sv
// One-bit 2:1 multiplexer used as the arbiter datapath slice.
module mux21 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/arb2_stream.sv
// Two-input round-robin valid/ready merge with a one-entry output buffer.
// Optional grant counters are built when ARB2_STATS_EN is defined.
module arb2_stream
    import arb2_pkg::*;
#(
    parameter int WIDTH = 8
`ifdef ARB2_STATS_EN
    , parameter int CNT_W = 16
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d0,
    input  logic             v0,
    output logic             r0,
    input  logic [WIDTH-1:0] d1,
    input  logic             v1,
    output logic             r1,
    output logic             sel,
    output logic [WIDTH-1:0] q,
    output logic             vq,
    input  logic             rq
`ifdef ARB2_STATS_EN
    , output logic [CNT_W-1:0] cnt0
    , output logic [CNT_W-1:0] cnt1
`endif
);

    src_t             last;
    src_t             grant;
    buf_state_t       state;
    buf_state_t       state_nxt;
    logic             space;
    logic             accept;
    logic [WIDTH-1:0] mux_y;

    // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        grant = last;
        if (v0 && !v1)
            grant = SRC0;
        else if (v1 && !v0)
            grant = SRC1;
        else if (v0 && v1)
            grant = (last == SRC0) ? SRC1 : SRC0;
    end

    assign sel    = grant;
    assign space  = (state == EMPTY) || rq;
    // Ready is held low throughout reset even though the empty buffer has space.
    assign r0     = !rst && space && (grant == SRC0);
    assign r1     = !rst && space && (grant == SRC1);
    assign accept = (v0 && r0) || (v1 && r1);
    assign vq     = (state == FULL);

    for (genvar i = 0; i < WIDTH; i++) begin : g_mux
        mux21 u_mux (
            .d0  (d0[i]),
            .d1  (d1[i]),
            .sel (grant),
            .y   (mux_y[i])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = FULL;
            FULL:    if (rq && !accept) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            last  <= LAST_RST;
            q     <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                q    <= mux_y;
                last <= grant;
            end
        end
    end

`ifdef ARB2_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (accept) begin
            if (grant == SRC0 && cnt0 != '1)
                cnt0 <= cnt0 + 1'b1;
            if (grant == SRC1 && cnt1 != '1)
                cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_arb2_stream.sv
// Scoreboard bench for arb2_stream: the driver queues expected output words, a monitor checks drains.
module tb_arb2_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d0  = '0;
    logic       v0  = 1'b0;
    logic       r0;
    logic [7:0] d1  = '0;
    logic       v1  = 1'b0;
    logic       r1;
    logic       sel;
    logic [7:0] q;
    logic       vq;
    logic       rq  = 1'b0;
`ifdef ARB2_STATS_EN
    logic [1:0] cnt0;
    logic [1:0] cnt1;
`endif

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    arb2_stream #(
        .WIDTH (8)
`ifdef ARB2_STATS_EN
        , .CNT_W (2)
`endif
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .d0   (d0),
        .v0   (v0),
        .r0   (r0),
        .d1   (d1),
        .v1   (v1),
        .r1   (r1),
        .sel  (sel),
        .q    (q),
        .vq   (vq),
        .rq   (rq)
`ifdef ARB2_STATS_EN
        , .cnt0 (cnt0)
        , .cnt1 (cnt1)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle of stimulus; ready is checked mid-cycle and accepted words are queued.
    task automatic cycle(input logic iv0, input logic [7:0] id0, input logic iv1,
                         input logic [7:0] id1, input logic irq, input logic er0, input logic er1);
        @(posedge clk);
        #1;
        v0 = iv0; d0 = id0; v1 = iv1; d1 = id1; rq = irq;
        @(negedge clk);
        check("r0", r0, er0);
        check("r1", r1, er1);
        if (er0 && iv0) exp_q.push_back(id0);
        if (er1 && iv1) exp_q.push_back(id1);
    endtask

    always @(negedge clk) begin
        if (!rst && vq && rq) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL q_unexpected: got %0h with nothing queued at %0t", q, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (q !== e) begin
                    errors++;
                    $display("FAIL q_out: got %0h expected %0h at %0t", q, e, $time);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state, with inputs that would otherwise raise ready.
        v0 = 1'b1; d0 = 8'h77; rq = 1'b1;
        #12;
        check("rst_r0", r0, 0);
        check("rst_r1", r1, 0);
        check("rst_vq", vq, 0);
        check("rst_q", q, 8'h00);
        check("rst_sel_v0", sel, 0);
        v0 = 1'b0;
        #1;
        check("rst_sel_idle", sel, 1);
        rq = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single word, then idle: one-cycle latency, drain, q retained.
        cycle(1'b1, 8'hA5, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("lat_vq", vq, 1);
        check("lat_q", q, 8'hA5);
        check("lat_sel", sel, 0);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("drain_vq", vq, 0);
        check("drain_q", q, 8'hA5);

        // Backpressure: full buffer with rq low blocks both readies.
        cycle(1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
            check("bp_sel", sel, 1);
            check("bp_vq", vq, 1);
            check("bp_q", q, 8'h3C);
        end
        cycle(1'b0, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("refill_vq", vq, 1);
        check("refill_q", q, 8'h5A);

        // Asynchronous reset discards the buffered word.
        rst = 1'b1;
        #1;
        check("arst_vq", vq, 0);
        check("arst_q", q, 8'h00);
        check("arst_r0", r0, 0);
        check("arst_r1", r1, 0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Fairness: continuous contention alternates starting with source 0.
        for (int k = 0; k < 6; k++)
            cycle(1'b1, 8'h11, 1'b1, 8'h22, 1'b1, (k % 2) == 0, (k % 2) == 1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        check("fair_idle_vq", vq, 0);
        check("fair_idle_q", q, 8'h22);

`ifdef ARB2_STATS_EN
        // Saturating grant counters with a 2-bit width.
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        check("cnt0_rst", cnt0, 0);
        check("cnt1_rst", cnt1, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 8'(k + 1), 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
            check("cnt0", cnt0, (k > 3) ? 3 : k);
            check("cnt1", cnt1, 0);
        end
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("cnt0_sat", cnt0, 3);
        cycle(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        check("cnt_idle_vq", vq, 0);
`endif

        @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
